// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution result-drain path.
package conv_pkg;

  localparam int unsigned CONV_N = 8;

  // Number of valid convolution results for an image of the given side.
  function automatic int unsigned q_of(input int unsigned side);
    return (side - 2) * (side - 2);
  endfunction

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_READ  = 2'd1,
    DRAIN_FLUSH = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic              last;
    logic              last_row;
    logic [CONV_N-1:0] data;
  } drain_entry_t;

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous circular FIFO with occupancy count; head is read combinationally.
module drain_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_c, do_pop_c;

  assign do_push_c = push_i && (count_q != CW'(DEPTH));
  assign do_pop_c  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push_c && !do_pop_c)      count_d = count_q + CW'(1);
    else if (!do_push_c && do_pop_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/conv_drain.sv
// Drains a finished convolution frame from the result RAM, applies optional
// ReLU, and streams it out with row/frame markers under credit-based flow control.
module conv_drain #(
  parameter int unsigned p     = 5,
  parameter int unsigned m     = 6,
  parameter int unsigned n     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done,
  input  logic         relu_en,
  output logic         conv_rd,
  output logic [m-1:0] conv_adr,
  input  logic [n-1:0] conv_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic         out_last_row,
  output logic         out_last,
  output logic         busy,
  output logic         overrun
);
  import conv_pkg::*;

  localparam int unsigned Q    = q_of(p);
  localparam int unsigned CW   = (p - 2 > 1) ? $clog2(p - 2) : 1;
  localparam int unsigned EW   = $bits(drain_entry_t);
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam int unsigned CRW  = CNTW + 1;

  drain_state_e  state_q, state_d;
  logic [m-1:0]  idx_q, idx_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          relu_q, relu_d;
  logic          inflight_q;
  logic          overrun_q;

  logic            issue_c;
  logic            credit_c;
  logic            pop_c;
  logic [CNTW-1:0] count_c;
  logic [CRW-1:0]  used_c;
  logic [n-1:0]    word_c;
  drain_entry_t    push_entry_c;
  drain_entry_t    head_entry_c;
  logic [EW-1:0]   head_bits_c;

  // Words already in the FIFO plus the read still in flight must fit.
  assign used_c   = CRW'(count_c) + CRW'(inflight_q);
  assign credit_c = used_c < CRW'(DEPTH);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    relu_d  = relu_q;
    row_d   = row_q;
    col_d   = col_q;
    issue_c = 1'b0;

    if (inflight_q) begin
      if (col_q == CW'(p - 3)) begin
        col_d = '0;
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    unique case (state_q)
      DRAIN_IDLE: begin
        if (done) begin
          relu_d  = relu_en;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = DRAIN_READ;
        end
      end
      DRAIN_READ: begin
        if (credit_c) begin
          issue_c = 1'b1;
          idx_d   = idx_q + m'(1);
          if (idx_q == m'(Q - 1)) state_d = DRAIN_FLUSH;
        end
      end
      DRAIN_FLUSH: begin
        if ((count_c == '0) && !inflight_q) state_d = DRAIN_IDLE;
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DRAIN_IDLE;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      relu_q     <= 1'b0;
      inflight_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      col_q      <= col_d;
      relu_q     <= relu_d;
      inflight_q <= issue_c;
      overrun_q  <= done && (state_q != DRAIN_IDLE);
    end
  end

  // RAM data is only meaningful the cycle after a read strobe.
  assign word_c                = (relu_q && conv_data[n-1]) ? '0 : conv_data;
  assign push_entry_c.data     = CONV_N'(word_c);
  assign push_entry_c.last_row = (col_q == CW'(p - 3));
  assign push_entry_c.last     = (row_q == CW'(p - 3)) && (col_q == CW'(p - 3));

  assign pop_c = out_valid && out_ready;

  drain_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (push_entry_c),
    .pop_i       (pop_c),
    .head_o      (head_bits_c),
    .count_o     (count_c)
  );

  assign head_entry_c = drain_entry_t'(head_bits_c);

  assign conv_rd      = issue_c;
  assign conv_adr     = idx_q;
  assign out_valid    = (count_c != '0);
  assign out_data     = out_valid ? n'(head_entry_c.data) : '0;
  assign out_last_row = out_valid && head_entry_c.last_row;
  assign out_last     = out_valid && head_entry_c.last;
  assign busy         = (state_q != DRAIN_IDLE);
  assign overrun      = overrun_q;

endmodule
